// File: rtl/mem_lsu.sv
// mem_lsu: load/store front end for a 36-bit single-ported memory
// (one-cycle read latency, even parity bit per byte in [35:32]).
//
// Parameters:
//   WIDTH  - word address width of the memory (byte address is WIDTH+2 bits)
//   PARITY - 1: generate/check parity; 0: parity bits driven 0, never flagged
//
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   req_valid/req_ready       - request handshake
//   req_write, req_size       - store/load, 0=byte 1=half 2=word 3=illegal
//   req_unsigned              - loads: zero-extend (1) or sign-extend (0)
//   req_addr, req_wdata       - byte address, right-aligned store data
//   rsp_valid/rsp_ready       - response handshake
//   rsp_rdata                 - aligned/extended load data (0 otherwise)
//   rsp_misaligned            - misaligned or illegal size, no access made
//   rsp_parity_err            - parity mismatch in an accessed byte of a load
//   mem_valid, mem_write      - memory strobe and direction
//   mem_wmask, mem_wdata      - byte mask, {parity[3:0], data[31:0]}
//   mem_addr, mem_rdata       - word address, read data (one cycle later)
module mem_lsu #(
    parameter int unsigned WIDTH  = 13,
    parameter bit          PARITY = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [WIDTH+1:0]   req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_misaligned,
    output logic               rsp_parity_err,
    output logic               mem_valid,
    output logic               mem_write,
    output logic [3:0]         mem_wmask,
    output logic [35:0]        mem_wdata,
    output logic [WIDTH-1:0]   mem_addr,
    input  logic [35:0]        mem_rdata
);

    // Stage 1 state
    logic        s1_valid_q, s1_valid_d;
    logic        s1_write_q, s1_write_d;
    logic [1:0]  s1_size_q, s1_size_d;
    logic        s1_unsigned_q, s1_unsigned_d;
    logic [1:0]  s1_off_q, s1_off_d;
    logic        s1_mis_q, s1_mis_d;
    logic        fresh_q, fresh_d;
    logic [31:0] hold_rdata_q, hold_rdata_d;
    logic        hold_perr_q, hold_perr_d;

    logic        misaligned;
    logic        accept;
    logic [31:0] wdata_rep;
    logic [3:0]  wpar;
    logic [31:0] shifted;
    logic [31:0] fmt_rdata;
    logic        fmt_perr;
    logic [3:0]  lane_en;
    logic [3:0]  lane_err;

    // ---------------- request side ----------------
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = (req_addr[1:0] != 2'b00);
            2'd3:    misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    assign req_ready = ~rst & (~s1_valid_q | rsp_ready);
    assign accept    = req_valid & req_ready;
    assign mem_valid = accept & ~misaligned;
    assign mem_write = req_write;
    assign mem_addr  = req_addr[WIDTH+1:2];

    always_comb begin
        mem_wmask = '0;
        wdata_rep = req_wdata;
        case (req_size)
            2'd0: begin
                wdata_rep = {4{req_wdata[7:0]}};
                mem_wmask = 4'b0001 << req_addr[1:0];
            end
            2'd1: begin
                wdata_rep = {2{req_wdata[15:0]}};
                mem_wmask = req_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'd2:    mem_wmask = 4'b1111;
            default: mem_wmask = 4'b0000;
        endcase
        if (!req_write) begin
            mem_wmask = 4'b0000;
        end
        wpar = '0;
        if (PARITY) begin
            for (int unsigned i = 0; i < 4; i++) begin
                wpar[i] = ^wdata_rep[8*i +: 8];
            end
        end
    end

    assign mem_wdata = {wpar, wdata_rep};

    // ---------------- response formatting ----------------
    always_comb begin
        shifted   = mem_rdata[31:0] >> {s1_off_q, 3'b000};
        fmt_rdata = shifted;
        lane_en   = 4'b1111;
        case (s1_size_q)
            2'd0: begin
                fmt_rdata = s1_unsigned_q ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
                lane_en   = 4'b0001 << s1_off_q;
            end
            2'd1: begin
                fmt_rdata = s1_unsigned_q ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
                lane_en   = s1_off_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                fmt_rdata = shifted;
                lane_en   = 4'b1111;
            end
        endcase
        for (int unsigned i = 0; i < 4; i++) begin
            lane_err[i] = (^mem_rdata[8*i +: 8]) ^ mem_rdata[32+i];
        end
        fmt_perr = PARITY ? |(lane_en & lane_err) : 1'b0;
        if (s1_write_q || s1_mis_q) begin
            fmt_rdata = '0;
            fmt_perr  = 1'b0;
        end
    end

    assign rsp_valid      = s1_valid_q & ~rst;
    assign rsp_rdata      = rsp_valid ? (fresh_q ? fmt_rdata : hold_rdata_q) : '0;
    assign rsp_parity_err = rsp_valid & (fresh_q ? fmt_perr : hold_perr_q);
    assign rsp_misaligned = rsp_valid & s1_mis_q;

    // ---------------- stage 1 next state ----------------
    always_comb begin
        s1_valid_d    = s1_valid_q;
        s1_write_d    = s1_write_q;
        s1_size_d     = s1_size_q;
        s1_unsigned_d = s1_unsigned_q;
        s1_off_d      = s1_off_q;
        s1_mis_d      = s1_mis_q;
        fresh_d       = fresh_q;
        hold_rdata_d  = hold_rdata_q;
        hold_perr_d   = hold_perr_q;
        if (accept) begin
            s1_valid_d    = 1'b1;
            s1_write_d    = req_write;
            s1_size_d     = req_size;
            s1_unsigned_d = req_unsigned;
            s1_off_d      = req_addr[1:0];
            s1_mis_d      = misaligned;
            fresh_d       = 1'b1;
        end else if (rsp_valid && rsp_ready) begin
            s1_valid_d = 1'b0;
            fresh_d    = 1'b0;
        end else if (rsp_valid && fresh_q) begin
            // Memory read data is only valid for one cycle; freeze the
            // formatted result so a stalled consumer still sees it.
            hold_rdata_d = fmt_rdata;
            hold_perr_d  = fmt_perr;
            fresh_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_write_q    <= 1'b0;
            s1_size_q     <= '0;
            s1_unsigned_q <= 1'b0;
            s1_off_q      <= '0;
            s1_mis_q      <= 1'b0;
            fresh_q       <= 1'b0;
            hold_rdata_q  <= '0;
            hold_perr_q   <= 1'b0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_write_q    <= s1_write_d;
            s1_size_q     <= s1_size_d;
            s1_unsigned_q <= s1_unsigned_d;
            s1_off_q      <= s1_off_d;
            s1_mis_q      <= s1_mis_d;
            fresh_q       <= fresh_d;
            hold_rdata_q  <= hold_rdata_d;
            hold_perr_q   <= hold_perr_d;
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed testbench for mem_lsu with a 36-bit one-cycle-latency memory model.
module tb_mem_lsu;

    localparam int unsigned WIDTH = 13;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]       req_size;
    logic [WIDTH+1:0] req_addr;
    logic [31:0]      req_wdata;
    logic             rsp_valid, rsp_ready, rsp_misaligned, rsp_parity_err;
    logic [31:0]      rsp_rdata;
    logic             mem_valid, mem_write;
    logic [3:0]       mem_wmask;
    logic [35:0]      mem_wdata, mem_rdata;
    logic [WIDTH-1:0] mem_addr;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_in_rst = 0;

    mem_lsu #(.WIDTH(WIDTH), .PARITY(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_misaligned(rsp_misaligned), .rsp_parity_err(rsp_parity_err),
        .mem_valid(mem_valid), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: byte-masked writes, registered read every cycle.
    logic [35:0] mem [0:(1<<WIDTH)-1];
    logic [35:0] rd_q = '0;
    logic        flip_p33 = 1'b0;

    initial begin
        for (int i = 0; i < (1 << WIDTH); i++) mem[i] = '0;
    end

    always @(posedge clk) begin
        if (mem_valid && mem_write) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wmask[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                    mem[mem_addr][32+i]     <= mem_wdata[32+i];
                end
            end
        end
        rd_q <= mem[mem_addr];
        if (rst && mem_valid && mem_write) wr_in_rst <= wr_in_rst + 1;
    end

    assign mem_rdata = rd_q ^ {2'b00, flip_p33, 33'b0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [WIDTH+1:0] a, input logic [31:0] d);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = d;
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0;
        step(); step();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        rst = 1'b0;
        step();
        check("post_rst_req_ready", 64'(req_ready), 64'd1);
        check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);

        // Store word then load it back
        drive(1'b1, 2'd2, 1'b0, 'h10, 32'hDEADBEEF);
        check("sw_mem_valid", 64'(mem_valid), 64'd1);
        check("sw_wmask", 64'(mem_wmask), 64'hF);
        check("sw_wdata", 64'(mem_wdata), 64'h5DEADBEEF);
        check("sw_addr", 64'(mem_addr), 64'd4);
        step();
        check("sw_rsp_valid", 64'(rsp_valid), 64'd1);
        check("sw_rsp_rdata", 64'(rsp_rdata), 64'd0);
        drive(1'b0, 2'd2, 1'b0, 'h10, 32'h0);
        check("lw_wmask", 64'(mem_wmask), 64'd0);
        check("lw_mem_valid", 64'(mem_valid), 64'd1);
        step();
        check("lw_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        check("lw_perr", 64'(rsp_parity_err), 64'd0);
        check("lw_mis", 64'(rsp_misaligned), 64'd0);

        // Sub-word loads with extension
        drive(1'b0, 2'd0, 1'b0, 'h13, 32'h0);
        step();
        check("lb_signed", 64'(rsp_rdata), 64'hFFFFFFDE);
        drive(1'b0, 2'd0, 1'b1, 'h13, 32'h0);
        step();
        check("lbu", 64'(rsp_rdata), 64'h000000DE);
        drive(1'b0, 2'd1, 1'b0, 'h12, 32'h0);
        step();
        check("lh_signed", 64'(rsp_rdata), 64'hFFFFDEAD);

        // Byte store and misaligned half load
        drive(1'b1, 2'd0, 1'b0, 'h21, 32'h0000005A);
        check("sb_wmask", 64'(mem_wmask), 64'h2);
        check("sb_wdata", 64'(mem_wdata), 64'h05A5A5A5A);
        step();
        drive(1'b0, 2'd1, 1'b0, 'h23, 32'h0);
        check("mis_mem_valid", 64'(mem_valid), 64'd0);
        check("mis_req_ready", 64'(req_ready), 64'd1);
        step();
        check("mis_rsp_valid", 64'(rsp_valid), 64'd1);
        check("mis_flag", 64'(rsp_misaligned), 64'd1);
        check("mis_rdata", 64'(rsp_rdata), 64'd0);

        // Parity error injection on lane 1
        flip_p33 = 1'b1;
        drive(1'b0, 2'd0, 1'b1, 'h11, 32'h0);
        step();
        check("perr_lane1", 64'(rsp_parity_err), 64'd1);
        check("perr_lane1_data", 64'(rsp_rdata), 64'h000000BE);
        drive(1'b0, 2'd0, 1'b1, 'h10, 32'h0);
        step();
        check("perr_lane0", 64'(rsp_parity_err), 64'd0);
        check("perr_lane0_data", 64'(rsp_rdata), 64'h000000EF);
        flip_p33 = 1'b0;

        // Back-pressure: first response stalled 3 cycles
        drive(1'b0, 2'd2, 1'b0, 'h10, 32'h0);
        step();
        rsp_ready = 1'b0;
        drive(1'b0, 2'd2, 1'b0, 'h20, 32'h0);
        check("bp_req_ready", 64'(req_ready), 64'd0);
        check("bp_mem_valid", 64'(mem_valid), 64'd0);
        check("bp_rdata0", 64'(rsp_rdata), 64'hDEADBEEF);
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_hold_valid", 64'(rsp_valid), 64'd1);
            check("bp_hold_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
            check("bp_hold_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(req_ready), 64'd1);
        check("bp_release_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        step();
        idle();
        check("bp_second_valid", 64'(rsp_valid), 64'd1);
        check("bp_second_rdata", 64'(rsp_rdata), 64'h00005A00);
        step();
        check("bp_drain", 64'(rsp_valid), 64'd0);

        // Reset with a pending response and a pending store
        drive(1'b0, 2'd2, 1'b0, 'h10, 32'h0);
        step();
        check("pre_rst_rsp_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b0;
        drive(1'b1, 2'd2, 1'b0, 'h10, 32'h12345678);
        rst = 1'b1;
        #1;
        check("in_rst_req_ready", 64'(req_ready), 64'd0);
        check("in_rst_mem_valid", 64'(mem_valid), 64'd0);
        check("in_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        step();
        check("rst_drop_rsp", 64'(rsp_valid), 64'd0);
        check("rst_no_write", 64'(wr_in_rst), 64'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        idle();
        check("rst_release_ready", 64'(req_ready), 64'd1);
        check("rst_release_rsp", 64'(rsp_valid), 64'd0);
        drive(1'b0, 2'd2, 1'b0, 'h10, 32'h0);
        step();
        idle();
        check("rst_mem_intact", 64'(rsp_rdata), 64'hDEADBEEF);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
